ov7670_capture: RTL and testbench

- Front-end stage fed directly by the OV7670 parallel bus; it drives the 3x3 blur stage that follows it.
- Assembles byte pairs into 12-bit RGB444 pixels.
- Generates column index, row-mod-4 index and full row index, plus a one-cycle write strobe per pixel.
- Frame-synchronises on VSYNC, so capture always starts at a clean frame boundary after reset.

---
 rtl/ov7670_capture_pkg.sv | 23 ++
 rtl/ov7670_capture_byte_pack.sv | 59 +++++
 rtl/ov7670_capture.sv | 181 ++++++++++++++++++
 tb/tb_ov7670_capture.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_capture_pkg.sv
// Shared widths, default frame geometry and capture FSM encoding for the OV7670 front end.
package ov7670_capture_pkg;

    localparam int RGB_W        = 12;
    localparam int X_W          = 10;
    localparam int Y_W          = 2;
    localparam int ROW_W        = 9;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

    localparam logic [1:0] ST_SYNC_WAIT = 2'd0;
    localparam logic [1:0] ST_VSYNC     = 2'd1;
    localparam logic [1:0] ST_HBLANK    = 2'd2;
    localparam logic [1:0] ST_LINE      = 2'd3;

    typedef enum logic [1:0] {
        SYNC_WAIT = ST_SYNC_WAIT,
        VSYNC     = ST_VSYNC,
        HBLANK    = ST_HBLANK,
        LINE      = ST_LINE
    } cap_state_t;

endpackage

// File: rtl/ov7670_capture_byte_pack.sv
// Byte-pair packer: latches the first byte of each pair and emits one RGB444 pixel
// plus a one-cycle done strobe when the second byte arrives.
module ov7670_byte_pack
    import ov7670_capture_pkg::*;
#(
    parameter bit HI_BYTE_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_start,
    input  logic             i_en,
    input  logic             i_abort,
    input  logic [7:0]       i_byte,
    output logic [RGB_W-1:0] o_pixel,
    output logic             o_done,
    output logic             o_half
);

    logic             r_phase;
    logic [7:0]       r_byte_a;
    logic [RGB_W-1:0] r_pixel;
    logic             r_done;
    logic [RGB_W-1:0] w_pixel;

    generate
        if (HI_BYTE_FIRST) begin : g_hi_first
            assign w_pixel = {r_byte_a[3:0], i_byte};
        end else begin : g_lo_first
            assign w_pixel = {i_byte[3:0], r_byte_a};
        end
    endgenerate

    // i_start carries byte A of a fresh line, so it always restarts at phase 0
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_phase  <= 1'b0;
            r_byte_a <= '0;
            r_pixel  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                r_phase <= 1'b0;
            end else if (i_start || (i_en && !r_phase)) begin
                r_byte_a <= i_byte;
                r_phase  <= 1'b1;
            end else if (i_en) begin
                r_pixel <= w_pixel;
                r_done  <= 1'b1;
                r_phase <= 1'b0;
            end
        end
    end

    assign o_pixel = r_pixel;
    assign o_done  = r_done;
    assign o_half  = r_phase;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture front end: frame-synchronised byte-pair assembly with column/row
// tracking, per-pixel write strobe and line/frame/error status.
module ov7670_capture
    import ov7670_capture_pkg::*;
#(
    parameter int H_ACTIVE      = DEF_H_ACTIVE,
    parameter int V_ACTIVE      = DEF_V_ACTIVE,
    parameter bit HI_BYTE_FIRST = 1'b1
) (
    input  logic             writeClk,
    input  logic             reset,
    input  logic             vsync,
    input  logic             href,
    input  logic [7:0]       dataIn,
    output logic [RGB_W-1:0] pixelOut,
    output logic             pixelValid,
    output logic [X_W-1:0]   outX,
    output logic [Y_W-1:0]   outY,
    output logic [ROW_W-1:0] outRow,
    output logic             lineDone,
    output logic             frameDone,
    output logic             syncErr
);

    localparam logic [X_W-1:0]   H_MAX = X_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0] V_MAX = ROW_W'(V_ACTIVE);

    cap_state_t       r_state, w_state_next;
    logic             r_vsync, r_vsync_d, r_href, r_href_d;
    logic [7:0]       r_data;
    logic             w_vsync_rise, w_vsync_fall, w_href_rise, w_href_fall;
    logic             w_start, w_en, w_abort, w_line_end, w_frame_end, w_row_clear;
    logic             w_done, w_half;
    logic [RGB_W-1:0] w_pixel;
    logic [X_W-1:0]   r_col;
    logic [ROW_W-1:0] r_row, w_row_after;
    logic             r_line_acc, w_accept, w_line_has_pix, w_err;
    logic [RGB_W-1:0] r_pixel_out;
    logic [X_W-1:0]   r_out_x;
    logic [ROW_W-1:0] r_out_row;
    logic             r_pixel_valid, r_line_done, r_frame_done, r_sync_err;

    always_ff @(posedge writeClk) begin
        if (reset) begin
            r_vsync   <= 1'b0;
            r_vsync_d <= 1'b0;
            r_href    <= 1'b0;
            r_href_d  <= 1'b0;
            r_data    <= '0;
        end else begin
            r_vsync   <= vsync;
            r_vsync_d <= r_vsync;
            r_href    <= href;
            r_href_d  <= r_href;
            r_data    <= dataIn;
        end
    end

    assign w_vsync_rise = r_vsync && !r_vsync_d;
    assign w_vsync_fall = !r_vsync && r_vsync_d;
    assign w_href_rise  = r_href && !r_href_d;
    assign w_href_fall  = !r_href && r_href_d;
    assign w_en         = (r_state == LINE) && r_href;

    always_ff @(posedge writeClk) begin
        if (reset) begin
            r_state <= SYNC_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_abort      = 1'b0;
        w_line_end   = 1'b0;
        w_frame_end  = 1'b0;
        w_row_clear  = 1'b0;
        case (r_state)
            SYNC_WAIT: begin
                if (r_vsync) w_state_next = VSYNC;
            end
            VSYNC: begin
                if (w_vsync_fall) begin
                    w_row_clear  = 1'b1;
                    w_state_next = HBLANK;
                end
            end
            HBLANK: begin
                if (w_vsync_rise) begin
                    w_frame_end  = 1'b1;
                    w_state_next = VSYNC;
                end else if (w_href_rise) begin
                    w_start      = 1'b1;
                    w_state_next = LINE;
                end
            end
            LINE: begin
                if (w_href_fall) begin
                    w_line_end   = 1'b1;
                    w_abort      = 1'b1;
                    w_state_next = HBLANK;
                end
                if (w_vsync_rise) begin
                    w_abort      = 1'b1;
                    w_frame_end  = 1'b1;
                    w_state_next = VSYNC;
                end
            end
            default: w_state_next = SYNC_WAIT;
        endcase
    end

    ov7670_byte_pack #(
        .HI_BYTE_FIRST(HI_BYTE_FIRST)
    ) u_pack (
        .i_clk  (writeClk),
        .i_srst (reset),
        .i_start(w_start),
        .i_en   (w_en),
        .i_abort(w_abort),
        .i_byte (r_data),
        .o_pixel(w_pixel),
        .o_done (w_done),
        .o_half (w_half)
    );

    // The last pair of a line completes in the same cycle the href fall is seen
    assign w_accept       = w_done && (r_col < H_MAX) && (r_row < V_MAX);
    assign w_line_has_pix = r_line_acc || w_accept;
    assign w_row_after    = (w_line_end && w_line_has_pix) ? r_row + ROW_W'(1) : r_row;
    assign w_err          = w_abort && (w_half || !w_href_fall);

    always_ff @(posedge writeClk) begin
        if (reset) begin
            r_col         <= '0;
            r_row         <= '0;
            r_line_acc    <= 1'b0;
            r_pixel_out   <= '0;
            r_out_x       <= '0;
            r_out_row     <= '0;
            r_pixel_valid <= 1'b0;
            r_line_done   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_pixel_valid <= w_accept;
            r_line_done   <= w_line_end && w_line_has_pix;
            r_frame_done  <= w_frame_end && (w_row_after != '0);
            if (w_accept) begin
                r_pixel_out <= w_pixel;
                r_out_x     <= r_col;
                r_out_row   <= r_row;
                r_line_acc  <= 1'b1;
            end
            if (w_start) begin
                r_col      <= '0;
                r_line_acc <= 1'b0;
            end else if (w_done && (r_col < H_MAX)) begin
                r_col <= r_col + X_W'(1);
            end
            if (w_row_clear) begin
                r_row <= '0;
            end else begin
                r_row <= w_row_after;
            end
            if (w_err) r_sync_err <= 1'b1;
        end
    end

    assign pixelOut   = r_pixel_out;
    assign pixelValid = r_pixel_valid;
    assign outX       = r_out_x;
    assign outRow     = r_out_row;
    assign outY       = r_out_row[Y_W-1:0];
    assign lineDone   = r_line_done;
    assign frameDone  = r_frame_done;
    assign syncErr    = r_sync_err;

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture on a reduced 8x6 frame with a transaction-level
// pixel/line/frame model and a per-cycle strobe checker.
module tb_ov7670_capture;

    localparam int H = 8;
    localparam int V = 6;

    logic        writeClk = 1'b0;
    logic        reset, vsync, href;
    logic [7:0]  dataIn;
    logic [11:0] pixelOut;
    logic        pixelValid;
    logic [9:0]  outX;
    logic [1:0]  outY;
    logic [8:0]  outRow;
    logic        lineDone, frameDone, syncErr;

    ov7670_capture #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .HI_BYTE_FIRST(1'b1)
    ) dut (
        .writeClk  (writeClk),
        .reset     (reset),
        .vsync     (vsync),
        .href      (href),
        .dataIn    (dataIn),
        .pixelOut  (pixelOut),
        .pixelValid(pixelValid),
        .outX      (outX),
        .outY      (outY),
        .outRow    (outRow),
        .lineDone  (lineDone),
        .frameDone (frameDone),
        .syncErr   (syncErr)
    );

    always #5 writeClk = ~writeClk;

    int cyc = 0;
    always @(posedge writeClk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] pix;
        int          x;
        int          row;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_vec = 0, n_err = 0;
    int   m_row = 0, m_lines = 0, m_frames = 0, m_seed = 0;
    bit   m_synced = 0, m_err = 0;
    int   got_lines = 0, got_frames = 0, strobes = 0, first_cyc = -1, max_x = 0, b2_edge = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every strobe must match the head of the model queue at exactly its due cycle
    always @(negedge writeClk) begin
        if (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
            chk("missed_strobe_due_cycle", cyc, exp_q[0].tag);
            exp_q.delete(0);
        end
        if (pixelValid) begin
            strobes++;
            if (first_cyc < 0) first_cyc = cyc;
            if (int'(outX) > max_x) max_x = int'(outX);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", int'(pixelValid), 0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_cycle", cyc, e.tag);
                chk("pixelOut", int'(pixelOut), int'(e.pix));
                chk("outX", int'(outX), e.x);
                chk("outRow", int'(outRow), e.row);
                chk("outY", int'(outY), e.row % 4);
            end
        end
        if (lineDone) got_lines++;
        if (frameDone) got_frames++;
    end

    task automatic step(input logic v, input logic h, input logic [7:0] d);
        @(negedge writeClk);
        vsync  = v;
        href   = h;
        dataIn = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge writeClk);
        reset = 1'b1; vsync = 1'b0; href = 1'b0; dataIn = 8'h00;
        repeat (3) @(negedge writeClk);
        reset    = 1'b0;
        m_synced = 0;
        m_row    = 0;
        m_err    = 0;
        $display("reset applied at cycle %0d", cyc);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pixelOut"}, int'(pixelOut), 0);
        chk({tag, "_pixelValid"}, int'(pixelValid), 0);
        chk({tag, "_outX"}, int'(outX), 0);
        chk({tag, "_outY"}, int'(outY), 0);
        chk({tag, "_outRow"}, int'(outRow), 0);
        chk({tag, "_lineDone"}, int'(lineDone), 0);
        chk({tag, "_frameDone"}, int'(frameDone), 0);
        chk({tag, "_syncErr"}, int'(syncErr), 0);
    endtask

    task automatic vsync_pulse();
        if (m_synced && m_row > 0) m_frames++;
        m_synced = 1;
        m_row    = 0;
        repeat (3) step(1'b1, 1'b0, 8'h00);
        idle(3);
        $display("vsync pulse: frameDone expected total %0d", m_frames);
    endtask

    // Drives one href-high burst; the model predicts each pixel from the byte pairs
    task automatic send_line(input int n_bytes, input bit incr, input logic [7:0] a, input logic [7:0] b);
        int         col = 0, acc = 0;
        logic [7:0] ba = 8'h00;
        logic [7:0] d;
        for (int i = 0; i < n_bytes; i++) begin
            if (incr) begin
                d = 8'(m_seed);
                m_seed++;
            end else begin
                d = (i % 2 == 0) ? a : b;
            end
            step(1'b0, 1'b1, d);
            if (i % 2 == 0) begin
                ba = d;
            end else begin
                if (i == 1) b2_edge = cyc + 1;
                if (m_synced && col < H && m_row < V) begin
                    exp_q.push_back('{{ba[3:0], d}, col, m_row, cyc + 3});
                    acc++;
                end
                if (col < H) col++;
            end
        end
        idle(6);
        if (m_synced && (n_bytes % 2 == 1)) m_err = 1;
        if (acc > 0) begin
            m_row++;
            m_lines++;
        end
        $display("line: %0d bytes, %0d pixels expected, next row %0d", n_bytes, acc, m_row);
    endtask

    task automatic checkpoint(input string tag);
        idle(2);
        chk({tag, "_lineDone_count"}, got_lines, m_lines);
        chk({tag, "_frameDone_count"}, got_frames, m_frames);
        chk({tag, "_syncErr"}, int'(syncErr), int'(m_err));
        chk({tag, "_pending_strobes"}, exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1; vsync = 1'b0; href = 1'b0; dataIn = 8'h00;
        do_reset();
        check_zero("reset");

        // No vsync yet: the line must be ignored
        strobes = 0;
        send_line(8, 1'b0, 8'h0A, 8'hBC);
        checkpoint("nosync");
        chk("nosync_strobes", strobes, 0);
        chk("nosync_outX", int'(outX), 0);

        vsync_pulse();
        strobes = 0; first_cyc = -1;
        send_line(8, 1'b0, 8'h0A, 8'hBC);
        checkpoint("line4");
        chk("line4_strobes", strobes, 4);
        chk("line4_pixelOut", int'(pixelOut), 12'hABC);
        chk("line4_lastX", int'(outX), 3);
        chk("line4_row", int'(outRow), 0);
        chk("line4_latency", first_cyc - b2_edge, 2);
        chk("line4_lineDone", got_lines, 1);

        vsync_pulse();
        checkpoint("frame1");
        chk("frame1_frameDone", got_frames, 1);

        // Full reduced frame plus one surplus line beyond V
        strobes = 0;
        for (int l = 0; l < V + 1; l++) send_line(2 * H, 1'b1, 8'h00, 8'h00);
        checkpoint("full");
        chk("full_strobes", strobes, H * V);
        chk("full_lastX", int'(outX), H - 1);
        chk("full_lastRow", int'(outRow), V - 1);
        chk("full_lineDone", got_lines, 1 + V);
        vsync_pulse();
        checkpoint("full_end");
        chk("full_frameDone", got_frames, 2);

        // Overlong line: column saturates, no error
        strobes = 0; max_x = 0;
        send_line(2 * (H + 2), 1'b1, 8'h00, 8'h00);
        checkpoint("long");
        chk("long_strobes", strobes, H);
        chk("long_maxX", max_x, H - 1);
        chk("long_syncErr", int'(syncErr), 0);

        // Odd byte count: sticky error, row still advances
        strobes = 0;
        send_line(7, 1'b1, 8'h00, 8'h00);
        checkpoint("odd");
        chk("odd_strobes", strobes, 3);
        chk("odd_syncErr", int'(syncErr), 1);
        send_line(4, 1'b1, 8'h00, 8'h00);
        checkpoint("after_odd");
        chk("after_odd_row", int'(outRow), 2);
        vsync_pulse();
        send_line(4, 1'b1, 8'h00, 8'h00);
        checkpoint("next_frame");
        chk("next_frame_syncErr", int'(syncErr), 1);

        // Reset right after byte A of a new line
        strobes = 0;
        step(1'b0, 1'b1, 8'h5A);
        do_reset();
        idle(2);
        check_zero("midreset");
        send_line(8, 1'b1, 8'h00, 8'h00);
        checkpoint("midreset_nosync");
        chk("midreset_nosync_strobes", strobes, 0);
        vsync_pulse();
        send_line(8, 1'b1, 8'h00, 8'h00);
        checkpoint("resume");
        chk("resume_strobes", strobes, 4);
        chk("resume_row", int'(outRow), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
